// File: rtl/dma_ctl_ci_pkg.sv
// Shared constants, state encoding and helpers for the CI-port DMA control engine.
package dma_ctl_ci_pkg;

    // Register select values carried in valueA[12:10]
    localparam logic [2:0] REG_WORDS      = 3'd0;
    localparam logic [2:0] REG_BUS_ADDR   = 3'd1;
    localparam logic [2:0] REG_MEM_ADDR   = 3'd2;
    localparam logic [2:0] REG_BLOCK_SIZE = 3'd3;
    localparam logic [2:0] REG_BURST_SIZE = 3'd4;
    localparam logic [2:0] REG_CTRL       = 3'd5;

    localparam int unsigned SEL_LSB = 10;
    localparam int unsigned WE_BIT  = 9;

    // CTRL write bits and STATUS read bits
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_DIR_BIT   = 1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_ERROR_BIT = 1;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StBegin,
        StTransfer,
        StEnd
    } dma_state_e;

    // Words in the next burst: a full burst, or whatever is left of the block.
    function automatic logic [9:0] burst_len(input logic [7:0] burst_size,
                                             input logic [9:0] remaining);
        logic [9:0] full;
        full = {2'b00, burst_size} + 10'd1;
        return (full < remaining) ? full : remaining;
    endfunction

endpackage

// File: rtl/dma_ctl_ci_regs.sv
// CI decode, transfer configuration registers and the registered CI response.
module dma_ctl_ci_regs
    import dma_ctl_ci_pkg::*;
#(
    parameter logic [7:0] CustomId = 8'd12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  ci_n_i,
    input  logic [31:0] value_a_i,
    input  logic [31:0] value_b_i,
    input  logic        busy_i,
    input  logic        error_i,
    input  logic [9:0]  words_i,
    output logic [31:0] result_o,
    output logic        data_valid_o,
    output logic        xfer_start_o,
    output logic        dir_o,
    output logic [9:0]  block_size_o,
    output logic [7:0]  burst_size_o
);

    logic        hit;
    logic        cfg_wr;
    logic [2:0]  sel;
    logic [31:0] rdata;

    logic [31:0] bus_addr_q;
    logic [8:0]  mem_addr_q;
    logic [9:0]  block_size_q;
    logic [7:0]  burst_size_q;
    logic        dir_q;
    logic [31:0] result_q;
    logic        data_valid_q;

    logic unused_value_a;
    assign unused_value_a = ^{value_a_i[31:13], value_a_i[8:0]};

    assign hit = start_i && (ci_n_i == CustomId);
    assign sel = value_a_i[SEL_LSB +: 3];
    // Busy-time writes are still acknowledged, they just don't land.
    assign cfg_wr = hit && value_a_i[WE_BIT] && !busy_i;

    assign xfer_start_o = cfg_wr && (sel == REG_CTRL) && value_b_i[CTRL_START_BIT];

    always_comb begin
        rdata = '0;
        case (sel)
            REG_WORDS:      rdata[9:0] = words_i;
            REG_BUS_ADDR:   rdata      = bus_addr_q;
            REG_MEM_ADDR:   rdata[8:0] = mem_addr_q;
            REG_BLOCK_SIZE: rdata[9:0] = block_size_q;
            REG_BURST_SIZE: rdata[7:0] = burst_size_q;
            REG_CTRL: begin
                rdata[STAT_BUSY_BIT]  = busy_i;
                rdata[STAT_ERROR_BIT] = error_i;
            end
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_addr_q   <= '0;
            mem_addr_q   <= '0;
            block_size_q <= '0;
            burst_size_q <= '0;
            dir_q        <= 1'b0;
            result_q     <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= hit;
            result_q     <= hit ? rdata : '0;
            if (cfg_wr) begin
                case (sel)
                    REG_BUS_ADDR:   bus_addr_q   <= value_b_i;
                    REG_MEM_ADDR:   mem_addr_q   <= value_b_i[8:0];
                    REG_BLOCK_SIZE: block_size_q <= value_b_i[9:0];
                    REG_BURST_SIZE: burst_size_q <= value_b_i[7:0];
                    REG_CTRL:       dir_q        <= value_b_i[CTRL_DIR_BIT];
                    default:        ;
                endcase
            end
        end
    end

    assign result_o     = result_q;
    assign data_valid_o = data_valid_q;
    assign dir_o        = dir_q;
    assign block_size_o = block_size_q;
    assign burst_size_o = burst_size_q;

endmodule

// File: rtl/dma_ctl_ci.sv
// CI-programmed DMA control engine: burst sequencing FSM and beat counters.
// Define DMACTLCI_BUS_ERROR_EN to enable bus_error abort handling and the error status bit.
module dma_ctl_ci
    import dma_ctl_ci_pkg::*;
#(
    parameter logic [7:0] customId = 8'd12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic [31:0] result,
    output logic        data_valid,
    output logic        bus_request,
    input  logic        bus_aquire,
    output logic        begin_transaction,
    output logic        end_transaction,
    input  logic        slave_busy,
    input  logic        in_valid,
    input  logic        bus_error
);

    dma_state_e state_q, state_d;
    logic [9:0] words_q, words_d;
    logic [9:0] beat_cnt_q, beat_cnt_d;
    logic [9:0] burst_len_q, burst_len_d;
    logic       error_q, error_d;
    logic       gap_q, gap_d;

    logic       busy;
    logic       xfer_start;
    logic       dir;
    logic [9:0] block_size;
    logic [7:0] burst_size;
    logic       beat;
    logic       err_in;

`ifdef DMACTLCI_BUS_ERROR_EN
    assign err_in = bus_error;
`else
    logic unused_bus_error;
    assign unused_bus_error = bus_error;
    assign err_in = 1'b0;
`endif

    assign busy = (state_q != StIdle);
    assign beat = dir ? !slave_busy : in_valid;

    dma_ctl_ci_regs #(
        .CustomId(customId)
    ) u_regs (
        .clk_i       (clock),
        .rst_i       (reset),
        .start_i     (start),
        .ci_n_i      (ciN),
        .value_a_i   (valueA),
        .value_b_i   (valueB),
        .busy_i      (busy),
        .error_i     (error_q),
        .words_i     (words_q),
        .result_o    (result),
        .data_valid_o(data_valid),
        .xfer_start_o(xfer_start),
        .dir_o       (dir),
        .block_size_o(block_size),
        .burst_size_o(burst_size)
    );

    always_comb begin
        state_d           = state_q;
        words_d           = words_q;
        beat_cnt_d        = beat_cnt_q;
        burst_len_d       = burst_len_q;
        error_d           = error_q;
        gap_d             = gap_q;
        bus_request       = 1'b0;
        begin_transaction = 1'b0;
        end_transaction   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (xfer_start) begin
                    words_d = '0;
                    error_d = 1'b0;
                    gap_d   = 1'b0;
                    if (block_size != '0) begin
                        state_d = StRequest;
                    end
                end
            end
            StRequest: begin
                // First cycle after a burst keeps the request low and ignores grant.
                bus_request = !gap_q;
                gap_d       = 1'b0;
                if (!gap_q && bus_aquire) begin
                    state_d = StBegin;
                end
            end
            StBegin: begin
                bus_request       = 1'b1;
                begin_transaction = 1'b1;
                beat_cnt_d        = '0;
                burst_len_d       = burst_len(burst_size, block_size - words_q);
                if (err_in) begin
                    error_d = 1'b1;
                    state_d = StEnd;
                end else begin
                    state_d = StTransfer;
                end
            end
            StTransfer: begin
                bus_request = 1'b1;
                if (err_in) begin
                    error_d = 1'b1;
                    state_d = StEnd;
                end else if (beat) begin
                    words_d    = words_q + 10'd1;
                    beat_cnt_d = beat_cnt_q + 10'd1;
                    if (beat_cnt_q + 10'd1 == burst_len_q) begin
                        state_d = StEnd;
                    end
                end
            end
            StEnd: begin
                bus_request     = 1'b1;
                end_transaction = 1'b1;
                if (error_q || (words_q >= block_size)) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRequest;
                    gap_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            words_q     <= '0;
            beat_cnt_q  <= '0;
            burst_len_q <= '0;
            error_q     <= 1'b0;
            gap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_len_q <= burst_len_d;
            error_q     <= error_d;
            gap_q       <= gap_d;
        end
    end

endmodule

// File: tb/tb_dma_ctl_ci.sv
// Randomized self-checking bench for dma_ctl_ci against a transaction-level reference model.
module tb_dma_ctl_ci;

`ifdef DMACTLCI_BUS_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [31:0] result;
    logic        data_valid;
    logic        bus_request;
    logic        bus_aquire;
    logic        begin_transaction;
    logic        end_transaction;
    logic        slave_busy;
    logic        in_valid;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    // Reference model of the programmer-visible state
    logic [31:0] m_bus_addr;
    logic [8:0]  m_mem_addr;
    logic [9:0]  m_block;
    logic [7:0]  m_burst;
    logic [9:0]  m_words;
    bit          m_dir;
    bit          m_busy;
    bit          m_err;

    dma_ctl_ci dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .ciN              (ciN),
        .valueA           (valueA),
        .valueB           (valueB),
        .result           (result),
        .data_valid       (data_valid),
        .bus_request      (bus_request),
        .bus_aquire       (bus_aquire),
        .begin_transaction(begin_transaction),
        .end_transaction  (end_transaction),
        .slave_busy       (slave_busy),
        .in_valid         (in_valid),
        .bus_error        (bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bus_addr = '0;
        m_mem_addr = '0;
        m_block    = '0;
        m_burst    = '0;
        m_words    = '0;
        m_dir      = 1'b0;
        m_busy     = 1'b0;
        m_err      = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] sel);
        case (sel)
            3'd0:    return {22'd0, m_words};
            3'd1:    return m_bus_addr;
            3'd2:    return {23'd0, m_mem_addr};
            3'd3:    return {22'd0, m_block};
            3'd4:    return {24'd0, m_burst};
            3'd5:    return {30'd0, m_err, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] sel, input logic [31:0] d);
        case (sel)
            3'd1: m_bus_addr = d;
            3'd2: m_mem_addr = d[8:0];
            3'd3: m_block    = d[9:0];
            3'd4: m_burst    = d[7:0];
            3'd5: begin
                m_dir = d[1];
                if (d[0]) begin
                    m_words = '0;
                    m_err   = 1'b0;
                    m_busy  = (m_block != 0);
                end
            end
            default: ;
        endcase
    endtask

    // One CI access; returns at the sampling point of the response cycle.
    task automatic ci_op(input logic [7:0] num, input logic [2:0] sel, input bit we,
                         input logic [31:0] wdata);
        logic [31:0] a;
        logic [31:0] exp;
        bit          hit;
        hit = (num == 8'd12);
        a = $urandom;
        a[12:10] = sel;
        a[9] = we;
        exp = model_read(sel);
        start = 1'b1;
        ciN = num;
        valueA = a;
        valueB = wdata;
        @(negedge clock);
        start = 1'b0;
        valueA = $urandom;
        valueB = $urandom;
        check_eq(hit ? "ci_dv" : "ci_nohit_dv", {31'd0, data_valid}, hit ? 32'd1 : 32'd0);
        check_eq(hit ? "ci_rd" : "ci_nohit_rd", result, hit ? exp : 32'd0);
        if (hit && we && !m_busy) model_write(sel, wdata);
    endtask

    task automatic cfg_and_start(input int blk, input int bst, input bit dir);
        ci_op(8'd12, 3'd1, 1'b1, $urandom);
        ci_op(8'd12, 3'd2, 1'b1, $urandom);
        ci_op(8'd12, 3'd3, 1'b1, blk);
        ci_op(8'd12, 3'd4, 1'b1, bst);
        ci_op(8'd12, 3'd5, 1'b1, {30'd0, dir, 1'b1});
    endtask

    // Acts as bus arbiter and slave; the block is split into bursts of
    // min(BURST_SIZE+1, remaining) and each handshake edge is checked per cycle.
    task automatic run_transfer(input bit err_first, input int stall);
        int exp_len[$];
        int rem, bl, bi, cnt, dly, cyc, tail, total, bcyc;
        bit exp_b, exp_e, gap, errored, waiting, in_burst, first_cyc, q, e, nb, ne, ngap;
        rem = int'(m_block);
        bl  = int'(m_burst) + 1;
        while (rem > 0) begin
            exp_len.push_back((bl < rem) ? bl : rem);
            rem -= (bl < rem) ? bl : rem;
        end
        bi = 0; cnt = 0; total = 0; bcyc = 0;
        exp_b = 0; exp_e = 0; gap = 0; errored = 0; waiting = 1; in_burst = 0; first_cyc = 1;
        dly = $urandom_range(0, 2);
        tail = (exp_len.size() == 0) ? 4 : -1;
        for (cyc = 0; cyc < 3000 && tail != 0; cyc++) begin
            nb = 0; ne = 0; ngap = 0;
            check_eq("begin_transaction", {31'd0, begin_transaction}, {31'd0, exp_b});
            check_eq("end_transaction", {31'd0, end_transaction}, {31'd0, exp_e});
            if (gap || tail >= 0) check_eq("bus_request_low", {31'd0, bus_request}, 32'd0);
            else if (first_cyc || in_burst) check_eq("bus_request_high", {31'd0, bus_request}, 32'd1);
            first_cyc = 0;
            bus_aquire = 1'b0;
            bus_error = 1'b0;
            in_valid = m_dir ? 1'($urandom) : 1'b0;
            slave_busy = m_dir ? 1'b1 : 1'($urandom);
            if (tail > 0) tail--;
            if (exp_e) begin
                in_burst = 0;
                bi++;
                ngap = 1;
                if (errored || bi == exp_len.size()) tail = 4;
                else begin
                    waiting = 1;
                    dly = $urandom_range(0, 2);
                end
            end else if (exp_b) begin
                in_burst = 1;
                cnt = 0;
                bcyc = 0;
            end else if (waiting && bus_request) begin
                if (dly == 0) begin
                    bus_aquire = 1'b1;
                    nb = 1;
                    waiting = 0;
                end else dly--;
            end else if (in_burst && cnt < exp_len[bi]) begin
                q = (bcyc >= stall) && ($urandom_range(0, 3) != 0);
                e = err_first && (bi == 0) && (bcyc == 0);
                if (e) begin
                    q = 1;
                    bus_error = 1'b1;
                end
                if (q) begin
                    if (m_dir) slave_busy = 1'b0;
                    else in_valid = 1'b1;
                end
                if (e && ERR_EN) begin
                    errored = 1;
                    ne = 1;
                end else if (q) begin
                    cnt++;
                    total++;
                    if (cnt == exp_len[bi]) ne = 1;
                end
                bcyc++;
            end
            exp_b = nb;
            exp_e = ne;
            gap = ngap;
            @(negedge clock);
        end
        check_eq("xfer_timeout", {31'd0, tail == 0}, 32'd1);
        bus_aquire = 1'b0;
        bus_error = 1'b0;
        in_valid = 1'b0;
        slave_busy = 1'b0;
        m_words = 10'(total);
        m_err = errored;
        m_busy = 1'b0;
    endtask

    initial begin
        logic [2:0]  sel;
        logic [31:0] d;
        logic [7:0]  num;
        reset = 1'b1;
        start = 1'b0;
        ciN = '0;
        valueA = '0;
        valueB = '0;
        bus_aquire = 1'b0;
        slave_busy = 1'b0;
        in_valid = 1'b0;
        bus_error = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_dv", {31'd0, data_valid}, 32'd0);
        check_eq("rst_req", {31'd0, bus_request}, 32'd0);
        check_eq("rst_begin", {31'd0, begin_transaction}, 32'd0);
        check_eq("rst_end", {31'd0, end_transaction}, 32'd0);
        reset = 1'b0;

        ci_op(8'd12, 3'd4, 1'b0, 32'd0);
        @(negedge clock);
        check_eq("dv_one_cycle", {31'd0, data_valid}, 32'd0);
        check_eq("result_idle", result, 32'd0);

        ci_op(8'd13, 3'd3, 1'b1, 32'h155);
        ci_op(8'd13, 3'd5, 1'b1, 32'h1);
        check_eq("nohit_no_req", {31'd0, bus_request}, 32'd0);
        ci_op(8'd12, 3'd3, 1'b0, 32'd0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);

        repeat (40) begin
            sel = 3'($urandom_range(0, 7));
            d = $urandom;
            if (sel == 3'd5) d[0] = 1'b0;
            num = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'd12;
            ci_op(num, sel, 1'($urandom), d);
        end

        cfg_and_start(4, 1, 1'b0);
        run_transfer(1'b0, 0);
        ci_op(8'd12, 3'd0, 1'b0, 32'd0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);

        cfg_and_start(3, 7, 1'b1);
        run_transfer(1'b0, 2);
        ci_op(8'd12, 3'd0, 1'b0, 32'd0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);

        repeat (6) begin
            cfg_and_start($urandom_range(1, 20), $urandom_range(0, 7), 1'($urandom));
            run_transfer(1'b0, $urandom_range(0, 2));
            ci_op(8'd12, 3'd0, 1'b0, 32'd0);
            ci_op(8'd12, 3'd5, 1'b0, 32'd0);
        end

        cfg_and_start(0, 3, 1'b0);
        run_transfer(1'b0, 0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);

        cfg_and_start(5, 2, 1'b0);
        run_transfer(1'b1, 0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);
        ci_op(8'd12, 3'd0, 1'b0, 32'd0);
        cfg_and_start(2, 0, 1'b1);
        run_transfer(1'b0, 0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);

        // Busy-time config write, then reset in the middle of a burst
        cfg_and_start(5, 1, 1'b0);
        check_eq("busy_req", {31'd0, bus_request}, 32'd1);
        ci_op(8'd12, 3'd3, 1'b1, 32'd9);
        ci_op(8'd12, 3'd3, 1'b0, 32'd0);
        ci_op(8'd12, 3'd5, 1'b0, 32'd0);
        bus_aquire = 1'b1;
        @(negedge clock);
        bus_aquire = 1'b0;
        check_eq("mid_begin", {31'd0, begin_transaction}, 32'd1);
        @(negedge clock);
        check_eq("mid_req", {31'd0, bus_request}, 32'd1);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        ciN = 8'd12;
        valueA = 32'h0000_0C00;
        @(negedge clock);
        check_eq("rst_mid_req", {31'd0, bus_request}, 32'd0);
        check_eq("rst_mid_begin", {31'd0, begin_transaction}, 32'd0);
        check_eq("rst_mid_end", {31'd0, end_transaction}, 32'd0);
        check_eq("rst_mid_dv", {31'd0, data_valid}, 32'd0);
        check_eq("rst_mid_result", result, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        model_reset();
        for (int r = 0; r < 8; r++) ci_op(8'd12, 3'(r), 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_ctl_ci.md
# dma_ctl_ci

Control-path DMA engine for the processor's custom-instruction (CI) port. Software programs transfer registers and starts transfers through CI accesses. The engine then sequences bus-master burst transactions using a request/grant/begin/end handshake, counting data beats until the programmed block is done. The address and data path lives outside this block.

## Interface
- customId, 8'd12: CI opcode this block answers to.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  CI start strobe, one cycle.
- ciN  in  8  CI number; the block responds only when it equals customId.
- valueA  in  32  CI operand A.
  - [12:10] register select.
  - [9] write enable.
- valueB  in  32  CI operand B; write data.
- result  out  32  CI read data.
- data_valid  out  1  CI done pulse.
- bus_request  out  1  bus-master request.
- bus_aquire  in  1  bus grant.
- begin_transaction  out  1  one-cycle burst start pulse.
- end_transaction  out  1  one-cycle burst end pulse.
- slave_busy  in  1  slave stall.
- in_valid  in  1  slave read-data beat valid.
- bus_error  in  1  slave error.

## Operation
Register map, selected by valueA[12:10]. All registers reset to 0.
- 0 WORDS: words transferred so far. Read-only, 10 bits.
- 1 BUS_ADDR: 32-bit bus start address.
- 2 MEM_ADDR: 9-bit buffer start address.
- 3 BLOCK_SIZE: 10-bit total words.
- 4 BURST_SIZE: 8-bit; burst length is BURST_SIZE+1 words.
- 5 CTRL/STATUS:
  - Write: bit0 = start transfer, bit1 = direction (0 read bus→buffer, 1 write buffer→bus).
  - Read: bit0 = busy, bit1 = error.
- 6, 7: read 0; writes ignored.
- Reads return the value zero-extended to 32 bits.

Configuration writes:
- Registers 1–4 and the direction bit are written only while idle. Writes while busy are acknowledged but have no effect.
- Writing CTRL bit0=1 while idle clears WORDS and the error flag, then starts the FSM.
- A start command with BLOCK_SIZE=0 completes with no bus activity.

FSM states:
- IDLE: all bus outputs low. Leaves on a start command.
- REQUEST: bus_request=1. Goes to BEGIN when bus_aquire=1.
- BEGIN: begin_transaction=1 for one cycle. Burst length = min(BURST_SIZE+1, BLOCK_SIZE−WORDS).
- TRANSFER: bus_request stays high. A beat is counted each cycle on:
  - in_valid=1, direction 0;
  - slave_busy=0, direction 1.
  - Goes to END when the burst count is reached.
- END: end_transaction=1 for one cycle. bus_request drops on the next cycle.
  - If WORDS < BLOCK_SIZE, go to REQUEST.
  - Otherwise, go to IDLE.
- busy = (state != IDLE).
- bus_request is deasserted for at least one cycle between bursts.

Bus error:
- bus_error=1 in BEGIN or TRANSFER goes to END.
- Sets the error flag, then goes to IDLE without further bursts.
- A beat qualified in the same cycle as bus_error is not counted.
- A loss of bus_aquire during a burst is ignored.

## Timing
- CI start with a matching ciN in cycle N:
  - data_valid=1 in cycle N+1 only.
  - result holds the read value in cycle N+1 and is 0 otherwise.
  - A register write takes effect at the end of cycle N.
- start with a non-matching ciN: no response; data_valid stays 0.
- CTRL start written in cycle N: FSM is in REQUEST in cycle N+1.
- Grant seen in cycle M: begin_transaction high in cycle M+1.
- Final beat counted in cycle K: end_transaction high in cycle K+1.
- Reset values:
  - result=0, data_valid=0, bus_request=0, begin_transaction=0, end_transaction=0.
  - State IDLE.
- Reset asserted mid-transfer: all outputs low at the next edge, and all registers are cleared.

## Configuration
- DMACTLCI_BUS_ERROR_EN defined: bus_error handling as in Operation.
- Undefined: bus_error is ignored, and the error status bit always reads 0.

## Structure
- Package dma_ctl_ci_pkg holds:
  - register-select constants (REG_WORDS … REG_CTRL);
  - the state enum (IDLE, REQUEST, BEGIN, TRANSFER, END);
  - CTRL bit positions.
- Sub-module dma_ctl_ci_regs holds the CI decode, register file and data_valid/result generation.
- The FSM and counters stay in the top level.

## Test plan
- Reset, then read reg 4: result=0, data_valid exactly one cycle after start.
- Set ciN=8'd13 with start: data_valid stays 0 and registers are unchanged.
- Program BLOCK_SIZE=4, BURST_SIZE=1, direction 0, then start, grant immediately and give 4 in_valid beats:
  - two request/begin/end bursts of 2 beats each;
  - WORDS reads 4 and busy reads 0.
- Program BLOCK_SIZE=3, BURST_SIZE=7, direction 1, holding slave_busy high 2 cycles: one burst of 3 beats, with end_transaction delayed by 2 cycles.
- Assert bus_error during the first beat: end_transaction follows, status reads 0x2, and no second bus_request is issued.
- Attempt to write BLOCK_SIZE while busy: value unchanged. Assert reset mid-burst: bus_request=0 at the next edge.
